// File: rtl/song_sequencer_if.sv
// Control and ROM bus between the song player host and the sequencer core.
interface song_sequencer_if #(
   parameter int unsigned SONG_BITS = 2,
   parameter int unsigned ADDR_BITS = 5
);
   logic                           play;
   logic [SONG_BITS-1:0]           song;
   logic                           loop;
   logic                           beat;
   logic [SONG_BITS+ADDR_BITS-1:0] rom_addr;
   logic [15:0]                    rom_data;
   logic                           new_note;
   logic [5:0]                     note;
   logic [5:0]                     duration;
   logic [2:0]                     metadata;
   logic                           song_done;
   logic                           busy;

   modport master (
      output play, song, loop, beat, rom_data,
      input  rom_addr, new_note, note, duration, metadata, song_done, busy
   );

   modport slave (
      input  play, song, loop, beat, rom_data,
      output rom_addr, new_note, note, duration, metadata, song_done, busy
   );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a per-song ROM word list, issuing notes, timing rests
// against a beat strobe, and looping or stopping at the end of the song.
module song_sequencer #(
   parameter int unsigned SONG_BITS = 2,
   parameter int unsigned ADDR_BITS = 5,
   parameter int unsigned REST_BITS = 6
) (
   input  logic            clk,
   input  logic            reset,
   song_sequencer_if.slave bus
);
   localparam int unsigned          RA_W     = SONG_BITS + ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_REST   = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   typedef struct packed {
      logic       is_rest;
      logic [5:0] note;
      logic [5:0] duration;
      logic [2:0] metadata;
   } rom_word_t;

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [REST_BITS-1:0] cnt_q, cnt_d;
   logic [REST_BITS-1:0] tgt_q, tgt_d;
   logic [REST_BITS-1:0] cnt_inc;
   logic [REST_BITS-1:0] rest_tgt;
   logic [SONG_BITS-1:0] song_q, song_d;
   logic                 end_pend_q, end_pend_d;
   logic                 new_note_q, new_note_d;
   logic                 song_done_q, song_done_d;
   logic                 busy_q, busy_d;
   logic [5:0]           note_q, note_d;
   logic [5:0]           duration_q, duration_d;
   logic [2:0]           metadata_q, metadata_d;
   logic [RA_W-1:0]      rom_addr_q, rom_addr_d;

   rom_word_t word;
   logic      word_end;
   logic      song_chg;
   logic      consume;

   assign word     = rom_word_t'(bus.rom_data);
   assign word_end = (bus.rom_data == 16'h0000);
   assign rest_tgt = bus.rom_data[9 +: REST_BITS];
   assign cnt_inc  = cnt_q + REST_BITS'(1);
   assign song_chg = (state_q != S_IDLE) && (bus.song != song_q);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state, pointer and rest bookkeeping; song change outranks pause
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      song_d     = song_q;
      end_pend_d = end_pend_q;
      consume    = 1'b0;

      if (song_chg) begin
         state_d    = S_FETCH;
         ptr_d      = '0;
         cnt_d      = '0;
         song_d     = bus.song;
         end_pend_d = 1'b0;
      end else if (state_q == S_IDLE) begin
         song_d = bus.song;
         ptr_d  = '0;
         cnt_d  = '0;
         if (bus.play) state_d = S_FETCH;
      end else if (!bus.play) begin
         // A paused DECODE drops its ROM word, so the read is redone on resume
         if (state_q == S_DECODE) state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (end_pend_q) begin
                  end_pend_d = 1'b0;
                  state_d    = bus.loop ? S_FETCH : S_DONE;
               end else begin
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (word_end) begin
                  ptr_d   = '0;
                  state_d = bus.loop ? S_FETCH : S_DONE;
               end else if (word.is_rest && (rest_tgt != '0)) begin
                  tgt_d   = rest_tgt;
                  cnt_d   = '0;
                  state_d = S_REST;
               end else begin
                  consume = 1'b1;
               end
            end
            S_REST: begin
               if (bus.beat && (cnt_q != tgt_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == tgt_q) consume = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Last word consumed: ptr wraps and song_done follows in the next FETCH
      if (consume) begin
         ptr_d      = ptr_q + ADDR_BITS'(1);
         end_pend_d = (ptr_q == PTR_LAST);
         state_d    = S_FETCH;
      end
   end

   // Output values registered alongside the state
   always_comb begin
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
      note_d      = note_q;
      duration_d  = duration_q;
      metadata_d  = metadata_q;

      if (!song_chg && bus.play) begin
         if ((state_q == S_DECODE) && !word_end && !word.is_rest) begin
            new_note_d = 1'b1;
            note_d     = word.note;
            duration_d = word.duration;
            metadata_d = word.metadata;
         end
         song_done_d = ((state_q == S_DECODE) && word_end) ||
                       ((state_q == S_FETCH) && end_pend_q);
      end

      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      rom_addr_d = {song_d, ptr_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         cnt_q       <= '0;
         tgt_q       <= '0;
         song_q      <= bus.song;
         end_pend_q  <= 1'b0;
         new_note_q  <= 1'b0;
         song_done_q <= 1'b0;
         busy_q      <= 1'b0;
         note_q      <= '0;
         duration_q  <= '0;
         metadata_q  <= '0;
         rom_addr_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         song_q      <= song_d;
         end_pend_q  <= end_pend_d;
         new_note_q  <= new_note_d;
         song_done_q <= song_done_d;
         busy_q      <= busy_d;
         note_q      <= note_d;
         duration_q  <= duration_d;
         metadata_q  <= metadata_d;
         rom_addr_q  <= rom_addr_d;
      end
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.new_note  = new_note_q;
   assign bus.note      = note_q;
   assign bus.duration  = duration_q;
   assign bus.metadata  = metadata_q;
   assign bus.song_done = song_done_q;
   assign bus.busy      = busy_q;

endmodule
